regfile_writeback: RTL
======================

// Module: regfile_writeback
// PURPOSE
//  Architectural GPR file plus writeback. It is the write side of the register
//  interface that operand decode reads: it takes each instruction's dest0/dest1
//  kind, selector and result value, and commits them to EAX..EDI.
//  It applies x86 partial-width merges (8-bit low/high byte, 16-bit low word).
//  A second destination is serialized into the following cycle.
//  Its register outputs drive the decoder's eax..edi inputs.
// PARAMETERS
//  RESET_ESP   32'h0000_0000  reset value of ESP; all other GPRs reset to 0
// PORTS
//  clk                  in   1   clock, rising edge
//  rst                  in   1   asynchronous, active-high reset
//  in_valid             in   1   writeback request valid
//  in_ready             out  1   block can accept a request this cycle
//  dest0_kind           in   2   `OPND_DEST_NONE / `OPND_DEST_REG / `OPND_DEST_MEM
//  dest0_sel            in   32  register selector; only [2:0] legal, [31:3] must be 0
//  dest0_val            in   32  result for dest0, right-aligned
//  dest1_kind           in   2   as dest0_kind
//  dest1_sel            in   32  as dest0_sel
//  dest1_val            in   32  result for dest1, right-aligned
//  reg_1byte            in   1   8-bit operand size (overrides 16-bit)
//  prefix_operand_16bit in   1   16-bit operand size
//  eax,ecx,edx,ebx      out  32  architectural GPRs, registered
//  esp,ebp,esi,edi      out  32  architectural GPRs, registered
//  wb_err               out  1   one-cycle pulse on an illegal destination
// BEHAVIOUR
//  Reset: all GPRs 0 except esp=RESET_ESP; state=IDLE; in_ready=1; wb_err=0.
//  - Reset mid-WB1 drops the pending dest1 write.
//  in_ready = (state==IDLE). Accept = in_valid & in_ready.
//  Width rules, applied per destination:
//  - Width is 8 if reg_1byte, else 16 if prefix_operand_16bit, else 32.
//  - 32-bit: reg[sel] <= val.
//  - 16-bit: reg[sel][15:0] <= val[15:0]; bits [31:16] are kept.
//  - 8-bit, sel 0..3 (AL,CL,DL,BL): reg[sel][7:0] <= val[7:0].
//  - 8-bit, sel 4..7 (AH,CH,DH,BH): reg[sel-4][15:8] <= val[7:0].
//  - Untouched bits always hold their value.
//  Regsel numbering: 0 eax, 1 ecx, 2 edx, 3 ebx, 4 esp, 5 ebp, 6 esi, 7 edi.
//  Legality: kind==REG and sel[31:3]==0 -> write. kind==NONE -> no-op.
//  - kind==MEM, kind==2'b11, or REG with nonzero sel[31:3] -> no write;
//    wb_err=1 in the cycle after that destination is processed.
//  FSM states: IDLE, WB1.
//  - IDLE, accept: dest0 commits at this edge.
//    If dest1_kind!=NONE, latch dest1_{kind,sel,val} and the width -> WB1;
//    otherwise stay in IDLE.
//  - WB1: in_ready=0. Commit the latched dest1 at this edge using the latched
//    width, then -> IDLE. Inputs are ignored.
//  Latency: a written value is visible on the GPR outputs 1 cycle after accept
//  for dest0, and 2 cycles after accept for dest1.
//  Same register in dest0 and dest1 (e.g. XCHG eax,eax): dest1 lands last and wins.
//  Throughput: 1 request/cycle for single-dest requests; 1 per 2 cycles when dual.
//  If both destinations are illegal, wb_err pulses twice, one cycle apart.
// STRUCTURE
//  defines.v holds the shared constants:
//  - OPND_DEST_NONE/REG/MEM and REG_EAX..REG_EDI (both already shared);
//  - add WB_ST_IDLE and WB_ST_WB1.
//  Sub-module gpr_merge (combinational), instantiated twice (dest0 path and
//  latched dest1 path):
//  - inputs: old-register mux, sel[2:0], width, val;
//  - outputs: target index [2:0], merged 32-bit value.
//  The top level holds the 8x32 register array, the FSM, the dest1 latch and
//  the error logic.
// TESTING
//  Reset with RESET_ESP=32'h1000 -> all GPRs 0, esp=32'h1000, in_ready=1.
//  32-bit dest0 REG sel=3 val=32'hDEADBEEF, dest1 NONE -> next cycle ebx=DEADBEEF;
//   in_ready stays 1.
//  ecx=32'h11223344; 8-bit dest0 sel=5 (CH) val=8'hAB -> ecx=32'h1122AB44.
//  ecx=32'h11223344; 16-bit dest0 sel=1 val=32'hFFFF5555 -> ecx=32'h11225555.
//  Dual dest, sel0=0 val=1, sel1=0 val=2:
//   - cycle+1: eax=1, in_ready=0;
//   - cycle+2: eax=2, in_ready=1.
//  dest0 MEM: wb_err pulses, no GPR changes.
//  dest0 sel=32'h8: wb_err pulses, no GPR changes.
//  Assert rst while in WB1 -> pending dest1 never written, state=IDLE.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the GPR writeback slice.
// Destination kinds, register numbers, FSM states and width codes.
package regfile_writeback_pkg;

  localparam logic [1:0] OPND_DEST_NONE = 2'd0;
  localparam logic [1:0] OPND_DEST_REG  = 2'd1;
  localparam logic [1:0] OPND_DEST_MEM  = 2'd2;

  localparam int NUM_GPR = 8;
  localparam int REG_EAX = 0;
  localparam int REG_ECX = 1;
  localparam int REG_EDX = 2;
  localparam int REG_EBX = 3;
  localparam int REG_ESP = 4;
  localparam int REG_EBP = 5;
  localparam int REG_ESI = 6;
  localparam int REG_EDI = 7;

  typedef enum logic {
    WB_ST_IDLE = 1'b0,
    WB_ST_WB1  = 1'b1
  } wb_state_t;

  typedef enum logic [1:0] {
    WB_W32 = 2'd0,
    WB_W16 = 2'd1,
    WB_W8  = 2'd2
  } width_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] sel;
    logic [31:0] val;
    width_t      width;
  } dest_t;

  // Byte size beats the 16-bit prefix.
  function automatic width_t width_of(
    input logic b8,
    input logic h16
  );
    if (b8)
      return WB_W8;
    if (h16)
      return WB_W16;
    return WB_W32;
  endfunction

  function automatic logic dest_legal(
    input logic [1:0]  kind,
    input logic [31:0] sel
  );
    return (kind == OPND_DEST_REG)
      && (sel[31:3] == 29'd0);
  endfunction

  function automatic logic dest_err(
    input logic [1:0]  kind,
    input logic [31:0] sel
  );
    return (kind != OPND_DEST_NONE)
      && !dest_legal(kind, sel);
  endfunction

endpackage

// File: rtl/regfile_writeback_gpr_merge.sv
// Partial-width merge of a result into its target GPR.
// AH..BH selectors fold onto the low four registers, byte 1.
module gpr_merge
  import regfile_writeback_pkg::*;
(
  input  logic [31:0] old_val,
  input  logic [2:0]  sel,
  input  width_t      width,
  input  logic [31:0] val,
  output logic [2:0]  idx,
  output logic [31:0] merged
);

  always_comb begin
    idx    = sel;
    merged = val;
    unique case (1'b1)
      (width == WB_W8) && sel[2]: begin
        idx    = {1'b0, sel[1:0]};
        merged = {old_val[31:16], val[7:0],
                  old_val[7:0]};
      end
      (width == WB_W8) && !sel[2]:
        merged = {old_val[31:8], val[7:0]};
      (width == WB_W16):
        merged = {old_val[31:16], val[15:0]};
      default:
        merged = val;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Architectural GPR file with x86 partial-width writeback.
// A second destination is held one cycle and committed from WB1.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter logic [31:0] RESET_ESP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  dest0_kind,
  input  logic [31:0] dest0_sel,
  input  logic [31:0] dest0_val,
  input  logic [1:0]  dest1_kind,
  input  logic [31:0] dest1_sel,
  input  logic [31:0] dest1_val,
  input  logic        reg_1byte,
  input  logic        prefix_operand_16bit,
  output logic [31:0] eax,
  output logic [31:0] ecx,
  output logic [31:0] edx,
  output logic [31:0] ebx,
  output logic [31:0] esp,
  output logic [31:0] ebp,
  output logic [31:0] esi,
  output logic [31:0] edi,
  output logic        wb_err
);

  logic [31:0] gpr [NUM_GPR];
  wb_state_t   state, state_nxt;
  dest_t       d1_q;
  width_t      w0;
  logic [2:0]  idx0, idx1;
  logic [31:0] old0, old1;
  logic [31:0] mrg0, mrg1;
  logic        accept, in_wb1;
  logic        wr0, wr1, err0, err1;

  assign in_ready = (state == WB_ST_IDLE);
  assign in_wb1   = (state == WB_ST_WB1);
  assign accept   = in_valid && in_ready;
  assign w0       = width_of(reg_1byte,
                      prefix_operand_16bit);

  assign wr0  = accept
    && dest_legal(dest0_kind, dest0_sel);
  assign err0 = accept
    && dest_err(dest0_kind, dest0_sel);
  assign wr1  = in_wb1
    && dest_legal(d1_q.kind, d1_q.sel);
  assign err1 = in_wb1
    && dest_err(d1_q.kind, d1_q.sel);

  gpr_merge u_merge0 (
    .old_val (old0),
    .sel     (dest0_sel[2:0]),
    .width   (w0),
    .val     (dest0_val),
    .idx     (idx0),
    .merged  (mrg0)
  );

  gpr_merge u_merge1 (
    .old_val (old1),
    .sel     (d1_q.sel[2:0]),
    .width   (d1_q.width),
    .val     (d1_q.val),
    .idx     (idx1),
    .merged  (mrg1)
  );

  assign old0 = gpr[idx0];
  assign old1 = gpr[idx1];

  always_comb begin
    state_nxt = state;
    unique case (state)
      WB_ST_IDLE:
        if (accept
            && dest1_kind != OPND_DEST_NONE)
          state_nxt = WB_ST_WB1;
      WB_ST_WB1:
        state_nxt = WB_ST_IDLE;
      default:
        state_nxt = WB_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= WB_ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      d1_q <= '0;
    else if (accept
             && dest1_kind != OPND_DEST_NONE)
      d1_q <= '{kind:  dest1_kind,
                sel:   dest1_sel,
                val:   dest1_val,
                width: w0};
  end

  // dest0 and dest1 never commit together: IDLE vs WB1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++)
        gpr[i] <= (i == REG_ESP) ? RESET_ESP
                                 : 32'd0;
    end else if (wr0) begin
      gpr[idx0] <= mrg0;
    end else if (wr1) begin
      gpr[idx1] <= mrg1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wb_err <= 1'b0;
    else
      wb_err <= err0 || err1;
  end

  assign eax = gpr[REG_EAX];
  assign ecx = gpr[REG_ECX];
  assign edx = gpr[REG_EDX];
  assign ebx = gpr[REG_EBX];
  assign esp = gpr[REG_ESP];
  assign ebp = gpr[REG_EBP];
  assign esi = gpr[REG_ESI];
  assign edi = gpr[REG_EDI];

endmodule
